// File: rtl/project_pwm_peripheral_pkg.sv
// Shared definitions for the PWM peripheral trip-zone stage: FSM state
// encoding, safe-state action codes and a saturating counter helper.
package project_pwm_peripheral_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_OST = 2'b01,
    ST_CBC = 2'b10
  } trip_state_t;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'b00,
    ACT_LOW    = 2'b01,
    ACT_HIGH   = 2'b10,
    ACT_FREEZE = 2'b11
  } trip_action_t;

  localparam int COUNT_W = 8;

  // Increment an 8-bit count, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/project_pwm_peripheral_trip_filter.sv
// Two-flop synchroniser for the active-low fault pin followed by a
// glitch filter: the synced fault must persist i_filter extra cycles
// before o_filt asserts; deassertion is immediate.
module project_pwm_peripheral_trip_filter
  import project_pwm_peripheral_pkg::*;
#(
  parameter int FILTER_W = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_trip_n,
  input  logic [FILTER_W-1:0] i_filter,
  output logic                o_filt
);

  localparam logic [FILTER_W-1:0] CNT_ZERO = {FILTER_W{1'b0}};
  localparam logic [FILTER_W-1:0] CNT_ONE  = {{(FILTER_W-1){1'b0}}, 1'b1};
  localparam logic [FILTER_W-1:0] CNT_MAX  = {FILTER_W{1'b1}};

  logic                sync1_r;
  logic                sync2_r;
  logic                trip_sync_s;
  logic [FILTER_W-1:0] cnt_r;

  // Bring the asynchronous pin into the clock domain; idle level is high.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= i_trip_n;
      sync2_r <= sync1_r;
    end
  end

  assign trip_sync_s = ~sync2_r;

  // Count consecutive synced fault cycles; held at zero while disabled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_r <= CNT_ZERO;
    end else if (!i_en || !trip_sync_s) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_filt = trip_sync_s & (cnt_r >= i_filter);

endmodule

// File: rtl/project_pwm_peripheral_tripzone.sv
// Trip-zone protection between the deadband outputs and the PWM pins.
// A filtered external fault or a software trip forces all channels to a
// programmed safe state, either latched (one-shot) or released at the
// next period boundary (cycle-by-cycle).
module project_pwm_peripheral_tripzone
  import project_pwm_peripheral_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int FILTER_W = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic [N_CH-1:0]     i_pwm,
  input  logic                i_trip_n,
  input  logic                i_force_trip,
  input  logic [FILTER_W-1:0] i_filter,
  input  logic                i_mode,
  input  logic                i_cbc_release,
  input  logic [1:0]          i_action,
  input  logic                i_clear,
  output logic [N_CH-1:0]     o_pwm,
  output logic                o_trip_active,
  output logic                o_trip_flag,
  output logic [7:0]          o_trip_count
);

  trip_state_t     state_r;
  logic            flag_r;
  logic [7:0]      count_r;
  logic [N_CH-1:0] hold_r;
  logic [N_CH-1:0] pwm_s;
  logic            filt_s;
  logic            trip_evt_s;
  logic            entry_s;
  logic            escalate_s;

  project_pwm_peripheral_trip_filter #(
    .FILTER_W (FILTER_W)
  ) u_trip_filter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (i_en),
    .i_trip_n (i_trip_n),
    .i_filter (i_filter),
    .o_filt   (filt_s)
  );

  assign trip_evt_s = i_en & (filt_s | i_force_trip);
  assign entry_s    = trip_evt_s & (state_r == ST_RUN);
  assign escalate_s = trip_evt_s & (state_r == ST_CBC) & ~i_mode;

  // Trip FSM with its status registers: flag, entry count and freeze snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r <= ST_RUN;
      flag_r  <= 1'b0;
      count_r <= 8'd0;
      hold_r  <= {N_CH{1'b0}};
    end else begin
      if (!i_en) begin
        state_r <= ST_RUN;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (trip_evt_s) begin
              state_r <= i_mode ? ST_CBC : ST_OST;
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_CBC: begin
            if (trip_evt_s && !i_mode) begin
              state_r <= ST_OST;
            end else if (i_cbc_release && !trip_evt_s) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_CBC;
            end
          end
          ST_OST: begin
            if (i_clear && !trip_evt_s) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_OST;
            end
          end
          default: state_r <= ST_RUN;
        endcase
      end

      // A new trip or an escalation wins over a simultaneous clear.
      if (entry_s || escalate_s) begin
        flag_r <= 1'b1;
      end else if (i_clear) begin
        flag_r <= 1'b0;
      end else begin
        flag_r <= flag_r;
      end

      // Only fresh entries from RUN are counted; clear restarts the count.
      if (entry_s) begin
        count_r <= i_clear ? 8'd1 : sat_inc8(count_r);
      end else if (i_clear) begin
        count_r <= 8'd0;
      end else begin
        count_r <= count_r;
      end

      if (entry_s) begin
        hold_r <= i_pwm;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Pin drive: zero during reset, pass-through in RUN, else the safe state.
  always_comb begin
    pwm_s = i_pwm;
    if (!i_reset) begin
      pwm_s = {N_CH{1'b0}};
    end else if ((state_r == ST_RUN) || (i_action == ACT_NONE)) begin
      pwm_s = i_pwm;
    end else begin
      case (i_action)
        ACT_LOW:    pwm_s = {N_CH{1'b0}};
        ACT_HIGH:   pwm_s = {N_CH{1'b1}};
        ACT_FREEZE: pwm_s = hold_r;
        default:    pwm_s = i_pwm;
      endcase
    end
  end

  assign o_pwm         = pwm_s;
  assign o_trip_active = (state_r != ST_RUN);
  assign o_trip_flag   = flag_r;
  assign o_trip_count  = count_r;

endmodule
